lb_window_sched: RTL and testbench
==================================

LB_WINDOW_SCHED -- requirements
Module: lb_window_sched

Interface
REQ-001 Parameter IMG_W, default 512: image width in pixels.
REQ-002 Parameter IMG_H, default 512: image height in rows.
REQ-003 Parameter AW, default 11: line-buffer address width; DEPTH = 2*IMG_W+3 (1027 at default).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pix_valid  input  1  upstream pixel present.
REQ-007 pix_data  input  16  upstream pixel value.
REQ-008 pix_ready  output  1  pixel accepted this cycle when high with pix_valid.
REQ-009 mem_csn  output  1  line-buffer chip select, active-low.
REQ-010 mem_wen  output  1  line-buffer write strobe, active-high; low means read.
REQ-011 mem_addr  output  AW  line-buffer address.
REQ-012 mem_wdata  output  16  line-buffer write data.
REQ-013 tap_valid  output  1  line-buffer read data for tap_idx is valid this cycle.
REQ-014 tap_idx  output  4  window tap 0..8, raster order (row*3+col).
REQ-015 tap_last  output  1  high with tap_idx==8.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when the frame's last window completes.

Function
REQ-018 The line buffer is single-port; each cycle the block SHALL issue at most one access: a write, a read, or nothing (mem_csn=1).
REQ-019 States SHALL be IDLE, FILL, READ, REFILL and DONE.
REQ-020 IDLE: pix_ready=1; an accepted pixel is written at wr_ptr=0, and the state SHALL move to FILL.
REQ-021 FILL/REFILL accepted pixels: mem_wen=1, mem_csn=0, mem_addr=wr_ptr, mem_wdata=pix_data, all in the acceptance cycle; wr_ptr then SHALL increment and wrap from DEPTH-1 to 0.
REQ-022 FILL SHALL end in the cycle of the DEPTH-th accepted write, with next state READ.
REQ-023 READ: pix_ready=0; for 9 consecutive cycles the block SHALL read tap k at (base + (k/3)*IMG_W + k%3) mod DEPTH, k=0..8; base=0 at frame start.
REQ-024 tap_valid, tap_idx and tap_last SHALL be registered one cycle after each read issue, aligned with the synchronous read data.
REQ-025 After tap 8, base SHALL advance by 1, or by 3 when the window column equals IMG_W-3; the advance wraps mod DEPTH.
REQ-026 After an advance of n (1 or 3), the block SHALL enter REFILL, accept exactly n pixels, then return to READ.
REQ-027 After the window at row IMG_H-3, column IMG_W-3, the block SHALL go to DONE instead, skipping REFILL.
REQ-028 DONE SHALL last one cycle with done=1 and pix_ready=0; the next state SHALL be IDLE, with wr_ptr, base and the row/col counters cleared.
REQ-029 The mod-DEPTH address sum SHALL be computed at AW+2 bits; a result at or above DEPTH has DEPTH subtracted once.
REQ-030 pix_valid without pix_ready SHALL cause no write and no pointer change; upstream holds data.
REQ-031 Windows per frame SHALL be (IMG_W-2)*(IMG_H-2), i.e. 260100 at defaults.

Reset
REQ-032 While rst=1, the block SHALL hold: state=IDLE; wr_ptr, base, row, col and tap counters at 0; mem_csn=1, mem_wen=0, mem_addr=0, mem_wdata=0, tap_valid=0, tap_idx=0, tap_last=0, done=0, busy=0. pix_ready is 0 during reset and 1 in the first cycle after release.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately; no done pulse is issued and no tap_valid follows.

Configuration
REQ-034 With LB_SCHED_STATS_EN defined, the block SHALL add output stall_cnt[31:0], counting cycles in REFILL with pix_valid=0. The counter is cleared by rst and on IDLE-to-FILL, and saturates at all-ones.
REQ-035 Without LB_SCHED_STATS_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Continuous pix_valid after reset -> writes at addresses 0..1026 over 1027 cycles, then reads 0,1,2,512,513,514,1024,1025,1026.
REQ-037 Window at column 509 of row 0 -> 3-pixel REFILL; next window base=512 (taps start 512,513,514).
REQ-038 Base 1026, tap 8 -> address (1026+1024+2) mod 1027 = 1025.
REQ-039 pix_valid dropped for 5 cycles in REFILL -> no writes, wr_ptr frozen; with LB_SCHED_STATS_EN, stall_cnt increases by 5.
REQ-040 Full frame with IMG_W=IMG_H=8 (DEPTH 19) -> 36 tap_last pulses, then one done pulse, then IDLE with pix_ready=1.
REQ-041 rst asserted at tap 4 of a window -> outputs at reset values the next cycle; a new frame then restarts writes at address 0.

Source files
------------

// File: rtl/lb_window_sched.sv
// lb_window_sched: 3x3 window read scheduler over a single-port circular line buffer.
// Defining LB_SCHED_STATS_EN adds the stall_cnt output (REFILL cycles starved of pixels).
module lb_window_sched #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic [15:0]   pix_data,
    output logic          pix_ready,
    output logic          mem_csn,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          tap_valid,
    output logic [3:0]    tap_idx,
    output logic          tap_last,
    output logic          busy,
`ifdef LB_SCHED_STATS_EN
    output logic [31:0]   stall_cnt,
`endif
    output logic          done
);
    localparam int DEPTH = 2*IMG_W+3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW+1:0] DEP = (AW+2)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, READ, REFILL, DONE} state_t;
    state_t state, nxt;

    logic [AW-1:0] wr_ptr, base, rd_addr, base_nxt;
    logic [3:0]    k;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    rf_left, adv;
    logic [AW+1:0] off, rd_sum, b_sum;
    logic          acc, rd, last_tap, edge_col, last_win;

    assign pix_ready = !rst && (state == IDLE || state == FILL || state == REFILL);
    assign acc       = pix_valid & pix_ready;
    assign rd        = state == READ;
    assign last_tap  = rd && k == 4'd8;
    assign edge_col  = col == CW'(IMG_W-3);
    assign last_win  = edge_col && row == RW'(IMG_H-3);
    assign adv       = edge_col ? 2'd3 : 2'd1;

    // Both sums stay below 2*DEPTH, so one conditional subtract wraps them.
    always_comb begin
        off = k >= 4'd6 ? (AW+2)'(2*IMG_W) + (AW+2)'(k - 4'd6)
            : k >= 4'd3 ? (AW+2)'(IMG_W) + (AW+2)'(k - 4'd3) : (AW+2)'(k);
        rd_sum = {2'b00, base} + off;
        rd_addr = rd_sum >= DEP ? AW'(rd_sum - DEP) : AW'(rd_sum);
        b_sum = {2'b00, base} + (AW+2)'(adv);
        base_nxt = b_sum >= DEP ? AW'(b_sum - DEP) : AW'(b_sum);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = acc ? FILL : IDLE;
            FILL:    nxt = acc && wr_ptr == AW'(DEPTH-1) ? READ : FILL;
            READ:    nxt = last_tap ? (last_win ? DONE : REFILL) : READ;
            REFILL:  nxt = acc && rf_left == 2'd1 ? READ : REFILL;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_wen = acc;
        mem_csn = !(acc || rd);
        mem_addr = acc ? wr_ptr : rd ? rd_addr : '0;
        mem_wdata = acc ? pix_data : '0;
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            base <= '0;
            k <= '0;
            col <= '0;
            row <= '0;
            rf_left <= '0;
            tap_valid <= 1'b0;
            tap_idx <= '0;
            tap_last <= 1'b0;
        end else begin
            wr_ptr <= state == DONE ? '0 : acc ? (wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1) : wr_ptr;
            base <= state == DONE ? '0 : last_tap ? base_nxt : base;
            k <= last_tap ? '0 : rd ? k + 4'd1 : k;
            col <= state == DONE || (last_tap && edge_col) ? '0 : last_tap ? col + 1'b1 : col;
            row <= state == DONE ? '0 : last_tap && edge_col ? row + 1'b1 : row;
            rf_left <= last_tap ? adv : state == REFILL && acc ? rf_left - 2'd1 : rf_left;
            tap_valid <= rd;
            tap_idx <= k;
            tap_last <= last_tap;
        end

`ifdef LB_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cnt <= '0;
        else if (state == IDLE && acc) stall_cnt <= '0;
        else if (state == REFILL && !pix_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_lb_window_sched.sv
// tb_lb_window_sched: random-valid frames on an 8x8 image checked against an
// access-sequence model derived from the window rules; includes mid-frame reset.
module tb_lb_window_sched;
    localparam int W = 8, H = 8, AW = 5, DEPTH = 2*W+3;

    logic clk = 1'b0, rst = 1'b1, pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic pix_ready, mem_csn, mem_wen, tap_valid, tap_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0] tap_idx;
`ifdef LB_SCHED_STATS_EN
    logic [31:0] stall_cnt;
    int m_stall = 0;
`endif

    typedef struct {int kind; int addr; int tap; bit refill;} ev_t;
    ev_t q[$];
    int vectors = 0, miss = 0;
    bit exp_tv = 1'b0, stall_done = 1'b0, aborted = 1'b0;
    int exp_ti = 0, pops = 0, tlast_cnt = 0, force_n = 0;

    lb_window_sched #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .mem_csn(mem_csn), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .tap_valid(tap_valid),
        .tap_idx(tap_idx), .tap_last(tap_last), .busy(busy),
`ifdef LB_SCHED_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected buffer traffic of one frame: kind 0 write, 1 read, 2 done.
    task automatic build_frame();
        int base = 0, wp = 0, n;
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back('{0, i, 0, 1'b0});
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++) begin
                for (int t = 0; t < 9; t++) q.push_back('{1, (base + (t/3)*W + t%3) % DEPTH, t, 1'b0});
                if (r == H-3 && c == W-3) q.push_back('{2, 0, 0, 1'b0});
                else begin
                    n = (c == W-3) ? 3 : 1;
                    base = (base + n) % DEPTH;
                    for (int j = 0; j < n; j++) begin
                        q.push_back('{0, wp, 0, 1'b1});
                        wp = (wp + 1) % DEPTH;
                    end
                end
            end
    endtask

    task automatic check_reset();
        chk("rst_csn", 32'(mem_csn), 1);
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_tap_valid", 32'(tap_valid), 0);
        chk("rst_tap_idx", 32'(tap_idx), 0);
        chk("rst_tap_last", 32'(tap_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix_ready", 32'(pix_ready), 0);
`ifdef LB_SCHED_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
    endtask

    task automatic cycle(input bit abort);
        ev_t e;
        if (force_n > 0) begin
            pix_valid = 1'b0;
            force_n--;
        end else if (!stall_done && q[0].refill) begin
            pix_valid = 1'b0;
            force_n = 4;
            stall_done = 1'b1;
        end else pix_valid = ($urandom_range(0, 3) != 0);
        pix_data = 16'($urandom);
        @(negedge clk);
        chk("tap_valid", 32'(tap_valid), 32'(exp_tv));
        if (exp_tv) begin
            chk("tap_idx", 32'(tap_idx), 32'(exp_ti));
            chk("tap_last", 32'(tap_last), 32'(exp_ti == 8));
        end
        if (tap_last === 1'b1) tlast_cnt++;
        chk("busy", 32'(busy), 32'(pops > 0));
`ifdef LB_SCHED_STATS_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
        e = q[0];
        exp_tv = 1'b0;
        if (e.kind == 0) begin
            chk("wr_pix_ready", 32'(pix_ready), 1);
            chk("wr_csn", 32'(mem_csn), 32'(!pix_valid));
            chk("wr_done", 32'(done), 0);
            if (pix_valid) begin
                chk("wr_wen", 32'(mem_wen), 1);
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(pix_data));
`ifdef LB_SCHED_STATS_EN
                if (pops == 0) m_stall = 0;
`endif
                void'(q.pop_front());
                pops++;
            end
`ifdef LB_SCHED_STATS_EN
            else if (e.refill) m_stall++;
`endif
        end else if (e.kind == 1) begin
            chk("rd_pix_ready", 32'(pix_ready), 0);
            chk("rd_csn", 32'(mem_csn), 0);
            chk("rd_wen", 32'(mem_wen), 0);
            chk("rd_addr", 32'(mem_addr), 32'(e.addr));
            exp_tv = 1'b1;
            exp_ti = e.tap;
            void'(q.pop_front());
            pops++;
            if (abort && e.tap == 4 && pops > 9*7) aborted = 1'b1;
        end else begin
            chk("done", 32'(done), 1);
            chk("done_pix_ready", 32'(pix_ready), 0);
            chk("done_csn", 32'(mem_csn), 1);
            chk("tap_last_count", 32'(tlast_cnt), 32'((W-2)*(H-2)));
            void'(q.pop_front());
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit abort);
        int cyc = 0;
        build_frame();
        pops = 0;
        tlast_cnt = 0;
        exp_tv = 1'b0;
        aborted = 1'b0;
        while (q.size() > 0 && !aborted && cyc < 4000) begin
            cycle(abort);
            cyc++;
        end
        if (aborted) return;
        chk("frame_complete", 32'(q.size()), 0);
        pix_valid = 1'b0;
        @(negedge clk);
        chk("idle_pix_ready", 32'(pix_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_csn", 32'(mem_csn), 1);
        chk("idle_done", 32'(done), 0);
        chk("idle_tap_valid", 32'(tap_valid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        pix_valid = 1'b1;
        pix_data = 16'hbeef;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("release_pix_ready", 32'(pix_ready), 1);
        chk("release_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        run_frame(1'b0);
        run_frame(1'b0);
        run_frame(1'b1);
        chk("abort_reached", 32'(aborted), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef LB_SCHED_STATS_EN
        m_stall = 0;
`endif
        run_frame(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
